reg_bank_32x32: RTL and testbench

- 32-entry × 32-bit register storage bank; the upstream stage of the register-file read path.
- Exposes all 32 registers as parallel buses Q0..Q31, wired directly to the I0..I31 inputs of the 32:1 read-select mux.
- Single synchronous write port with a 5-bit address; register 0 is optionally hardwired to zero (MIPS-style $zero).
- Purely storage plus write decode; read selection is done downstream.

---
 rtl/reg_bank_32x32_pkg.sv | 18 +
 rtl/reg_bank_32x32_reg_en_w.sv | 22 ++
 rtl/reg_bank_32x32.sv | 71 +++++++
 tb/tb_reg_bank_32x32.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_32x32_pkg.sv
// Shared register-file definitions: sizes, the $zero address and the write-address decoder.
package reg_bank_32x32_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = 5'd0;

  // Turns a write address into a one-hot vector with exactly one bit set.
  function automatic logic [REG_COUNT-1:0] onehot_decode(input logic [REG_ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] dec;
    dec       = '0;
    dec[addr] = 1'b1;
    return dec;
  endfunction

endpackage

// File: rtl/reg_bank_32x32_reg_en_w.sv
// One storage word: loads d when en is high, jumps to RESET_VAL as soon as rst_n drops.
module reg_en_w #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Enabled load; reset takes priority and does not wait for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_32x32.sv
// 32 x WIDTH register storage bank feeding the downstream 32:1 read mux.
// It has one synchronous write port. Register 0 can optionally be hardwired to zero.
module reg_bank_32x32
  import reg_bank_32x32_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter bit               ZERO_REG  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]      wd,
  output logic [WIDTH-1:0]      q0,  q1,  q2,  q3,  q4,  q5,  q6,  q7,
  output logic [WIDTH-1:0]      q8,  q9,  q10, q11, q12, q13, q14, q15,
  output logic [WIDTH-1:0]      q16, q17, q18, q19, q20, q21, q22, q23,
  output logic [WIDTH-1:0]      q24, q25, q26, q27, q28, q29, q30, q31,
  output logic                  wr_ack
);

  logic [REG_COUNT-1:0] wr_en;
  logic [WIDTH-1:0]     regs [REG_COUNT];

  // Per-register write enables. At most one bit is high, and none while we is low.
  always_comb begin
    wr_en = '0;
    if (we) begin
      wr_en = onehot_decode(wa);
    end
  end

  // The acknowledge echoes the write enable one cycle later. A write to $zero is still acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= we;
    end
  end

  // Build one storage word per address. The $zero slot becomes a constant when enabled.
  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    if (ZERO_REG && (i == int'(ZERO_ADDR))) begin : g_zero
      logic unused_en;
      assign unused_en = wr_en[i];
      assign regs[i]   = '0;
    end else begin : g_store
      reg_en_w #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wr_en[i]),
        .d     (wd),
        .q     (regs[i])
      );
    end
  end

  assign q0  = regs[0];   assign q1  = regs[1];   assign q2  = regs[2];   assign q3  = regs[3];
  assign q4  = regs[4];   assign q5  = regs[5];   assign q6  = regs[6];   assign q7  = regs[7];
  assign q8  = regs[8];   assign q9  = regs[9];   assign q10 = regs[10];  assign q11 = regs[11];
  assign q12 = regs[12];  assign q13 = regs[13];  assign q14 = regs[14];  assign q15 = regs[15];
  assign q16 = regs[16];  assign q17 = regs[17];  assign q18 = regs[18];  assign q19 = regs[19];
  assign q20 = regs[20];  assign q21 = regs[21];  assign q22 = regs[22];  assign q23 = regs[23];
  assign q24 = regs[24];  assign q25 = regs[25];  assign q26 = regs[26];  assign q27 = regs[27];
  assign q28 = regs[28];  assign q29 = regs[29];  assign q30 = regs[30];  assign q31 = regs[31];

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Directed bench for reg_bank_32x32.
// It drives two banks with the same inputs: one with $zero hardwiring and one without.
module tb_reg_bank_32x32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] qz [32];
  logic [31:0] qn [32];
  logic        ackz, ackn;

  logic [31:0] expz [32];
  logic [31:0] expn [32];

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  reg_bank_32x32 #(.WIDTH(32), .ZERO_REG(1'b1), .RESET_VAL(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .q0(qz[0]),   .q1(qz[1]),   .q2(qz[2]),   .q3(qz[3]),   .q4(qz[4]),   .q5(qz[5]),
    .q6(qz[6]),   .q7(qz[7]),   .q8(qz[8]),   .q9(qz[9]),   .q10(qz[10]), .q11(qz[11]),
    .q12(qz[12]), .q13(qz[13]), .q14(qz[14]), .q15(qz[15]), .q16(qz[16]), .q17(qz[17]),
    .q18(qz[18]), .q19(qz[19]), .q20(qz[20]), .q21(qz[21]), .q22(qz[22]), .q23(qz[23]),
    .q24(qz[24]), .q25(qz[25]), .q26(qz[26]), .q27(qz[27]), .q28(qz[28]), .q29(qz[29]),
    .q30(qz[30]), .q31(qz[31]), .wr_ack(ackz)
  );

  reg_bank_32x32 #(.WIDTH(32), .ZERO_REG(1'b0), .RESET_VAL(32'd0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .q0(qn[0]),   .q1(qn[1]),   .q2(qn[2]),   .q3(qn[3]),   .q4(qn[4]),   .q5(qn[5]),
    .q6(qn[6]),   .q7(qn[7]),   .q8(qn[8]),   .q9(qn[9]),   .q10(qn[10]), .q11(qn[11]),
    .q12(qn[12]), .q13(qn[13]), .q14(qn[14]), .q15(qn[15]), .q16(qn[16]), .q17(qn[17]),
    .q18(qn[18]), .q19(qn[19]), .q20(qn[20]), .q21(qn[21]), .q22(qn[22]), .q23(qn[23]),
    .q24(qn[24]), .q25(qn[25]), .q26(qn[26]), .q27(qn[27]), .q28(qn[28]), .q29(qn[29]),
    .q30(qn[30]), .q31(qn[31]), .wr_ack(ackn)
  );

  // Hold reset for 5 us while a write is being presented. Everything must stay cleared.
  task automatic test_reset();
    rst_n = 1'b0;
    we    = 1'b1;
    wa    = 5'd7;
    wd    = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      #1000;
      for (int r = 0; r < 32; r++) begin
        testsRun++;
        if (qz[r] !== 32'd0 || qn[r] !== 32'd0) begin
          testsFailed++;
          $display("[TB] FAIL reset_q%0d sample %0d: got %h/%h, want 0", r, k, qz[r], qn[r]);
        end
      end
      testsRun++;
      if (ackz !== 1'b0 || ackn !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL reset_ack sample %0d: got %b/%b, want 0", k, ackz, ackn);
      end
    end
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      expz[r] = 32'd0;
      expn[r] = 32'd0;
    end
  endtask

  // Write index+1 to registers 1..31 on consecutive edges. Only the addressed register may move.
  task automatic test_fill();
    for (int idx = 1; idx < 32; idx++) begin
      @(negedge clk);
      we = 1'b1;
      wa = 5'(idx);
      wd = 32'(idx + 1);
      expz[idx] = 32'(idx + 1);
      expn[idx] = 32'(idx + 1);
      @(posedge clk);
      #1;
      for (int r = 0; r < 32; r++) begin
        testsRun++;
        if (qz[r] !== expz[r] || qn[r] !== expn[r]) begin
          testsFailed++;
          $display("[TB] FAIL fill_w%0d_q%0d: got %h/%h, want %h/%h",
                   idx, r, qz[r], qn[r], expz[r], expn[r]);
        end
      end
      testsRun++;
      if (ackz !== 1'b1 || ackn !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL fill_ack_w%0d: got %b/%b, want 1", idx, ackz, ackn);
      end
    end
    @(negedge clk);
    we = 1'b0;
    testsRun++;
    if (qz[31] !== 32'd32) begin
      testsFailed++;
      $display("[TB] FAIL fill_q31: got %h, want %h", qz[31], 32'd32);
    end
    testsRun++;
    if (qz[25] !== 32'd26) begin
      testsFailed++;
      $display("[TB] FAIL mux_sel25: got %h, want %h", qz[25], 32'd26);
    end
  endtask

  // A write to address 0 is dropped by the $zero bank but still acknowledged. The plain bank stores it.
  task automatic test_zero_reg();
    @(negedge clk);
    we = 1'b1;
    wa = 5'd0;
    wd = 32'hFFFFFFFF;
    expn[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    testsRun++;
    if (qz[0] !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL zero_q0: got %h, want 0", qz[0]);
    end
    testsRun++;
    if (qn[0] !== 32'hFFFFFFFF) begin
      testsFailed++;
      $display("[TB] FAIL nonzero_q0: got %h, want ffffffff", qn[0]);
    end
    testsRun++;
    if (ackz !== 1'b1 || ackn !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_ack: got %b/%b, want 1", ackz, ackn);
    end
    @(negedge clk);
    we = 1'b0;
    @(posedge clk);
    #1;
    testsRun++;
    if (ackz !== 1'b0 || ackn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_ack_pulse: got %b/%b, want 0", ackz, ackn);
    end
    testsRun++;
    if (qz[0] !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL zero_q0_hold: got %h, want 0", qz[0]);
    end
  endtask

  // With we low, data and address on the bus must not reach any register.
  task automatic test_we_gating();
    @(negedge clk);
    we = 1'b0;
    wa = 5'd5;
    wd = 32'h12345678;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      testsRun++;
      if (qz[5] !== 32'd6 || qn[5] !== 32'd6) begin
        testsFailed++;
        $display("[TB] FAIL gate_q5 edge %0d: got %h/%h, want 6", e, qz[5], qn[5]);
      end
      testsRun++;
      if (ackz !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL gate_ack edge %0d: got %b, want 0", e, ackz);
      end
    end
  endtask

  // Two back-to-back writes to the same address. The second edge overwrites the first.
  task automatic test_back_to_back();
    @(negedge clk);
    we = 1'b1;
    wa = 5'd9;
    wd = 32'hA;
    @(posedge clk);
    #1;
    testsRun++;
    if (qz[9] !== 32'hA) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got %h, want a", qz[9]);
    end
    @(negedge clk);
    wd = 32'hB;
    @(posedge clk);
    #1;
    testsRun++;
    if (qz[9] !== 32'hB || qn[9] !== 32'hB) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got %h/%h, want b", qz[9], qn[9]);
    end
    expz[9] = 32'hB;
    expn[9] = 32'hB;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Drop reset between edges while a write is set up. Everything clears at once and the write is lost.
  task automatic test_async_reset();
    @(negedge clk);
    we = 1'b1;
    wa = 5'd3;
    wd = 32'd77;
    #2;
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) begin
      testsRun++;
      if (qz[r] !== 32'd0 || qn[r] !== 32'd0) begin
        testsFailed++;
        $display("[TB] FAIL async_q%0d: got %h/%h, want 0", r, qz[r], qn[r]);
      end
    end
    testsRun++;
    if (ackz !== 1'b0 || ackn !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL async_ack: got %b/%b, want 0", ackz, ackn);
    end
    @(posedge clk);
    #1;
    testsRun++;
    if (qz[3] !== 32'd0 || qn[3] !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL async_no_write: got %h/%h, want 0", qz[3], qn[3]);
    end
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      expz[r] = 32'd0;
      expn[r] = 32'd0;
    end
    @(negedge clk);
    we = 1'b1;
    wa = 5'd31;
    wd = 32'd99;
    expz[31] = 32'd99;
    expn[31] = 32'd99;
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) begin
      testsRun++;
      if (qz[r] !== expz[r] || qn[r] !== expn[r]) begin
        testsFailed++;
        $display("[TB] FAIL post_reset_q%0d: got %h/%h, want %h", r, qz[r], qn[r], expz[r]);
      end
    end
    testsRun++;
    if (ackz !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_ack: got %b, want 1", ackz);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_zero_reg();
    test_we_gating();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
